logical_shifter_right_seq: RTL and testbench
============================================

Name: logical_shifter_right_seq

Overview:
- Sequential logical right shifter; the right-shift counterpart of the team's combinational left barrel shifter.
- Shifts one bit position per clock under a START/BUSY/DONE handshake, zero-filling from the MSB.
- Sits in the datapath library as the area-cheap shifter for control paths where multi-cycle latency is acceptable.

Parameters:
- WIDTH, 8, data width of DI and SO.
- SEL_W, 3, width of shift-amount input SEL; maximum shift is 2^SEL_W-1. Legal only when 2^SEL_W-1 <= WIDTH.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- DI  input  WIDTH  operand; captured on the accepting edge.
- SEL  input  SEL_W  shift amount; captured on the accepting edge.
- SO  output  WIDTH  result register; DI >> SEL, zero-filled.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  high for exactly one cycle when SO holds a new result.

Behaviour:
- Reset (RST=1, asynchronous, any state):
  - state=IDLE, SO=0, BUSY=0, DONE=0, working register=0, counter=0.
  - Any operation in flight is aborted with no DONE.
  - Release is synchronous to the next CLK edge.
- States: IDLE, SHIFT, FIN. All outputs are registered or decoded from state; none depend combinationally on inputs.
- IDLE:
  - On an edge with START=1, load working reg=DI and cnt=SEL.
  - Next state is SHIFT if SEL!=0, else FIN.
  - START=0 keeps IDLE. DI and SEL are don't-care outside the accepting edge.
- SHIFT:
  - Each edge: working reg = {1'b0, reg[WIDTH-1:1]}, cnt = cnt-1.
  - When cnt==1 before the edge, next state is FIN and SO is loaded with the shifted value on that same edge.
- SEL==0 path: IDLE->FIN; SO is loaded with DI unchanged on the accepting edge.
- FIN: DONE=1, BUSY=1. The next edge returns unconditionally to IDLE.
- Latency: DONE is high in the cycle after SEL+1 rising edges, counting the accepting edge as edge 1. Examples: SEL=0 gives DONE one cycle after accept; SEL=7 gives it eight cycles after accept.
- Throughput: one operation per SEL+2 cycles. START is accepted again on the first edge in IDLE after FIN.
- START while BUSY=1 (SHIFT or FIN): ignored, not queued. The captured DI and SEL are unaffected.
- SO holds its last result from FIN until the next FIN or a reset. It does not show intermediate shift values.
- Zero fill: bits shifted out of the LSB are discarded and the MSB always fills with 0. There is no sign extension and no wrap-around.
- Counter is SEL_W bits wide and never underflows, because the SHIFT exit occurs at cnt==1.
- DONE and START are never both acted on in the same cycle, because START is sampled only in IDLE.

Test Plan:
- Reset release, then DI=8'hB6, SEL=3, START for 1 cycle -> BUSY=1 for 4 cycles, DONE pulse in cycle 4 after accept, SO=8'h16; SO holds 8'h16 afterwards.
- DI=8'hA5, SEL=0 -> FIN the cycle after accept, DONE=1 for one cycle, SO=8'hA5, BUSY=1 for exactly 1 cycle.
- DI=8'hFF, SEL=7 -> DONE 8 cycles after accept, SO=8'h01. Then DI=8'h80, SEL=7 -> SO=8'h01. Then DI=8'h7F, SEL=7 -> SO=8'h00.
- Accept DI=8'hF0, SEL=5, then hold START=1 with DI=8'h0F, SEL=1 throughout BUSY -> first result SO=8'h07. The second request is accepted only on the first IDLE edge after FIN and yields SO=8'h07 (8'h0F>>1) two cycles later; no extra DONE pulses.
- Accept DI=8'hC3, SEL=6, then assert RST asynchronously mid-SHIFT -> SO=0, BUSY=0, DONE=0 immediately with no DONE pulse. After release, DI=8'hC3, SEL=2 -> SO=8'h30.
- Randomised sweep of all 256 DI values by all 8 SEL values with random START gaps -> each DONE matches SO==(DI>>SEL) and the latency is SEL+1 edges.

Source files
------------

// File: rtl/logical_shifter_right_seq.sv
// -----------------------------------------------------------------------------
// logical_shifter_right_seq
// Sequential logical right shifter. An operand is captured on a START edge in
// IDLE and shifted right one bit per clock, MSB zero-filled, until the
// requested amount is consumed. The final value lands in the result register.
// DONE pulses for one cycle in FIN. BUSY covers every state except IDLE.
// The result register only changes when a new result is ready. It never shows
// partial shifts.
// -----------------------------------------------------------------------------
module logical_shifter_right_seq #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] di,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] so,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FIN   = 2'd2
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] work_reg;
   logic [SEL_W-1:0] cnt_reg;
   logic [WIDTH-1:0] so_reg;
   logic             busy_reg;
   logic             done_reg;

   // One-position logical right shift of the working register.
   logic [WIDTH-1:0] shift_next;

   // The MSB always takes a zero. Each lower bit takes its upper neighbour.
   assign shift_next[WIDTH-1] = 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
         assign shift_next[gi] = work_reg[gi+1];
      end
   endgenerate

   // Control FSM and datapath registers. All outputs are registered here.
   // The SHIFT exit is taken at cnt==1, so the counter never wraps below zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         work_reg  <= '0;
         cnt_reg   <= '0;
         so_reg    <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  work_reg <= di;
                  cnt_reg  <= sel;
                  busy_reg <= 1'b1;
                  if (sel == '0) begin
                     // Zero shift: the operand is the result, so skip SHIFT.
                     state_reg <= ST_FIN;
                     so_reg    <= di;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= ST_SHIFT;
                  end
               end
            end

            ST_SHIFT: begin
               work_reg <= shift_next;
               cnt_reg  <= cnt_reg - SEL_W'(1);
               if (cnt_reg == SEL_W'(1)) begin
                  // This is the last shift. Publish it on the same edge.
                  state_reg <= ST_FIN;
                  so_reg    <= shift_next;
                  done_reg  <= 1'b1;
               end
            end

            ST_FIN: begin
               // FIN lasts one cycle and always returns to IDLE.
               // Any START seen while in FIN is dropped.
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end

            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign so   = so_reg;
   assign busy = busy_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_logical_shifter_right_seq.sv
// -----------------------------------------------------------------------------
// tb_logical_shifter_right_seq
// Scoreboard bench for the sequential right shifter.
// The stimulus process pushes each accepted request with its expected result
// and its accept edge. A separate monitor pops an entry whenever DONE is seen.
// For each entry it checks the result, the latency in edges, and the length of
// the BUSY window.
// -----------------------------------------------------------------------------
module tb_logical_shifter_right_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] di;
   logic [2:0] sel;
   logic [7:0] so;
   logic       busy;
   logic       done;

   typedef struct {
      logic [7:0] so;
      int         sel;
      int         acc;
   } exp_t;

   exp_t sb_q[$];
   int   tests;
   int   fails;
   int   cyc;
   int   busy_run;

   logical_shifter_right_seq #(.WIDTH(8), .SEL_W(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .di    (di),
      .sel   (sel),
      .so    (so),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges. Stimulus and monitor only read the count on falling
   // edges.
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests = tests + 1;
      if (act !== req) begin
         fails = fails + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor. On every DONE, pop the oldest pending request and compare.
   initial begin
      exp_t e;
      busy_run = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_run = 0;
         end else begin
            if (busy) busy_run = busy_run + 1;
            else      busy_run = 0;
            if (done) begin
               if (sb_q.size() == 0) begin
                  tests = tests + 1;
                  fails = fails + 1;
                  $display("[TB] FAIL extra_done: DONE with no pending request, so=%h (cycle %0d)", so, cyc);
               end else begin
                  e = sb_q.pop_front();
                  $display("[TB] done sel=%0d so=%h exp=%h latency=%0d busy_cycles=%0d",
                           e.sel, so, e.so, cyc - e.acc + 1, busy_run);
                  check("so", 32'(so), 32'(e.so));
                  check("latency_edges", 32'(cyc - e.acc + 1), 32'(e.sel + 1));
                  check("busy_cycles", 32'(busy_run), 32'(e.sel + 1));
               end
            end
         end
      end
   end

   // Issue one request. The task waits, with a bound, until the DUT is IDLE,
   // then lets one edge accept the request.
   // With hold=1, START stays high after the accept.
   task automatic issue(input logic [7:0] d, input logic [2:0] s,
                        input logic [7:0] exp_so, input bit hold);
      int n;
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      di    = d;
      sel   = s;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n = n + 1;
      end
      if (busy) begin
         tests = tests + 1;
         fails = fails + 1;
         $display("[TB] FAIL accept_timeout: busy=%b, expected 0 within 200 cycles", busy);
         start = 1'b0;
         return;
      end
      e.so  = exp_so;
      e.sel = int'(s);
      e.acc = cyc + 1;
      sb_q.push_back(e);
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   // Wait, with a bound, for every pending request to complete.
   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n = n + 1;
      end
      if (sb_q.size() != 0) begin
         tests = tests + 1;
         fails = fails + 1;
         $display("[TB] FAIL drain_timeout: %0d requests pending, expected 0", sb_q.size());
         sb_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst   = 1'b1;
      start = 1'b0;
      di    = 8'h00;
      sel   = 3'd0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_so", 32'(so), 32'h00);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_done", 32'(done), 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // B6 >> 3 = 16, then SO must hold the result
      issue(8'hB6, 3'd3, 8'h16, 1'b0);
      drain();
      repeat (3) @(negedge clk);
      check("so_hold", 32'(so), 32'h16);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_done", 32'(done), 32'h0);

      // Zero shift
      issue(8'hA5, 3'd0, 8'hA5, 1'b0);
      drain();

      // Maximum shift
      issue(8'hFF, 3'd7, 8'h01, 1'b0);
      issue(8'h80, 3'd7, 8'h01, 1'b0);
      issue(8'h7F, 3'd7, 8'h00, 1'b0);
      drain();

      // START held high through BUSY. The second request waits for IDLE.
      issue(8'hF0, 3'd5, 8'h07, 1'b1);
      issue(8'h0F, 3'd1, 8'h07, 1'b0);
      drain();

      // Asynchronous reset in the middle of SHIFT aborts the operation
      issue(8'hC3, 3'd6, 8'h00, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_so", 32'(so), 32'h00);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      issue(8'hC3, 3'd2, 8'h30, 1'b0);
      drain();

      // Sweep of every DI by every SEL, with random idle gaps between requests
      for (int d = 0; d < 256; d++) begin
         for (int s = 0; s < 8; s++) begin
            issue(8'(d), 3'(s), 8'(d) >> s, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time bound
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, %0d requests pending", sb_q.size());
      $fatal(1, "watchdog");
   end

endmodule
